seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Each refresh slot selects one digit and presents that digit's 4-bit code to the existing code-to-pattern decoder. The decoder outputs active-low segments and treats code 4'hF as blank.
- Drives the active-low digit anodes and the active-low decimal point.
- Applies a ghosting guard interval between digits.
- Double-buffers host data so a frame is never torn.

---
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with guard interval and double buffer
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int GUARD  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [3:0]            code,
  output logic [DIGITS-1:0]     an,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    act_data_q, act_data_d, pnd_data_q, pnd_data_d;
  logic [DIGITS-1:0]      act_en_q, act_en_d, pnd_en_q, pnd_en_d;
  logic [DIGITS-1:0]      act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic                   pend_q, pend_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [3:0]             code_q, code_d;
  logic                   dp_n_q, dp_n_d;
  logic                   fd_q, fd_d;
  logic                   frame_end;

  assign frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  // Slot counter and digit index advance; both wrap at the end of the frame.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: loads park in pending; active only changes on the frame boundary edge.
  always_comb begin
    act_data_d = act_data_q;
    act_en_d   = act_en_q;
    act_dp_d   = act_dp_q;
    pnd_data_d = pnd_data_q;
    pnd_en_d   = pnd_en_q;
    pnd_dp_d   = pnd_dp_q;
    pend_d     = pend_q;
    if (frame_end) begin
      if (load) begin
        act_data_d = data;
        act_en_d   = digit_en;
        act_dp_d   = dp;
      end else if (pend_q) begin
        act_data_d = pnd_data_q;
        act_en_d   = pnd_en_q;
        act_dp_d   = pnd_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pnd_data_d = data;
      pnd_en_d   = digit_en;
      pnd_dp_d   = dp;
      pend_d     = 1'b1;
    end
  end

  // Outputs are computed from next-state so the registers show the current slot's view.
  always_comb begin
    an_d   = '1;
    code_d = 4'hF;
    dp_n_d = 1'b1;
    if ((cnt_d >= CNT_GUARD) && act_en_d[idx_d]) begin
      an_d   = ~(DIGITS'(1) << idx_d);
      code_d = act_data_d[{idx_d, 2'b00} +: 4];
      dp_n_d = ~act_dp_d[idx_d];
    end
    fd_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // State and output registers; reset clears everything, pending data included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      pnd_data_q <= '0;
      pnd_en_q   <= '0;
      pnd_dp_q   <= '0;
      pend_q     <= 1'b0;
      an_q       <= '1;
      code_q     <= 4'hF;
      dp_n_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      pnd_data_q <= pnd_data_d;
      pnd_en_q   <= pnd_en_d;
      pnd_dp_q   <= pnd_dp_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      code_q     <= code_d;
      dp_n_q     <= dp_n_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign code       = code_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a frame-level model
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int DV    = 8;
  localparam int GD    = 2;
  localparam int FRAME = D * DV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   data = '0;
  logic [3:0]    digit_en = '0;
  logic [3:0]    dp = '0;
  logic          load = 1'b0;
  logic [3:0]    code;
  logic [3:0]    an;
  logic          dp_n;
  logic          frame_done;

  seg_scan_ctrl #(.DIGITS(D), .DIV(DV), .GUARD(GD)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .digit_en(digit_en), .dp(dp),
    .load(load), .code(code), .an(an), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] d; logic [3:0] e; logic [3:0] p; } load_t;
  typedef struct { int ph; int cyc; logic [9:0] exp; } lit_t;

  load_t lq[$];
  lit_t  lits[$];
  int    cyc = 0;
  int    phase = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  // {an, code, dp_n, frame_done}
  function automatic logic [9:0] model(int t);
    int f = t / FRAME;
    int slot = (t % FRAME) / DV;
    int c = t % DV;
    logic [15:0] md = '0;
    logic [3:0] me = '0, mp = '0;
    logic [3:0] ea = 4'hF, ec = 4'hF;
    logic ed = 1'b1, ef;
    foreach (lq[i]) if (lq[i].cyc < f * FRAME) begin
      md = lq[i].d; me = lq[i].e; mp = lq[i].p;
    end
    if (c >= GD && me[slot]) begin
      ea = ~(4'b0001 << slot);
      ec = md[slot*4 +: 4];
      ed = ~mp[slot];
    end
    ef = ((t % FRAME) == FRAME - 1);
    return {ea, ec, ed, ef};
  endfunction

  task automatic chk(string name, logic [9:0] got, logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, exp);
    end
  endtask

  // Per-cycle compare against the model, plus literal pins and the one-anode rule.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      cyc = 0;
      lq.delete();
      chk("reset_vals", {an, code, dp_n, frame_done}, {4'hF, 4'hF, 1'b1, 1'b0});
    end else begin
      chk("model", {an, code, dp_n, frame_done}, model(cyc));
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL one_anode cyc=%0d got=%b required=at most one low", cyc, an);
      end
      foreach (lits[i]) if (lits[i].ph == phase && lits[i].cyc == cyc)
        chk("literal", {an, code, dp_n, frame_done}, lits[i].exp);
      if (load) lq.push_back('{cyc, data, digit_en, dp});
      cyc++;
    end
  end

  task automatic wait_cyc(int n);
    int k = 0;
    while (cyc != n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_timeout got=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic do_load(int n, logic [15:0] d, logic [3:0] e, logic [3:0] p);
    wait_cyc(n);
    data = d; digit_en = e; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    // phase 1: idle frame, then several loads including a mid-frame override
    lits.push_back('{1, 0,  {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{1, 20, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{1, 31, {4'hF, 4'hF, 1'b1, 1'b1}});
    lits.push_back('{1, 33, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{1, 34, {4'b1110, 4'h0, 1'b1, 1'b0}});
    lits.push_back('{1, 45, {4'b1101, 4'h1, 1'b1, 1'b0}});
    lits.push_back('{1, 52, {4'b1011, 4'h2, 1'b0, 1'b0}});
    lits.push_back('{1, 57, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{1, 63, {4'b0111, 4'h3, 1'b1, 1'b1}});
    lits.push_back('{1, 66, {4'b1110, 4'hB, 1'b0, 1'b0}});
    lits.push_back('{1, 90, {4'b0111, 4'hE, 1'b1, 1'b0}});
    lits.push_back('{1, 98, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{1, 106, {4'b1101, 4'h5, 1'b0, 1'b0}});
    lits.push_back('{1, 123, {4'b0111, 4'hF, 1'b1, 1'b0}});
    // phase 2: load on the boundary cycle replaces a pending load
    lits.push_back('{2, 35, {4'b1110, 4'h1, 1'b1, 1'b0}});
    lits.push_back('{2, 43, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{2, 63, {4'hF, 4'hF, 1'b1, 1'b1}});
    lits.push_back('{2, 66, {4'b1110, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{2, 74, {4'b1101, 4'h7, 1'b1, 1'b0}});
    lits.push_back('{2, 92, {4'b0111, 4'h5, 1'b0, 1'b0}});
    // phase 3: after mid-frame reset, nothing may light
    lits.push_back('{3, 40, {4'hF, 4'hF, 1'b1, 1'b0}});
    lits.push_back('{3, 63, {4'hF, 4'hF, 1'b1, 1'b1}});

    repeat (3) @(negedge clk);
    phase = 1;
    rst_n = 1'b1;
    do_load(3,  16'h3210, 4'b1111, 4'b0100);
    do_load(40, 16'hEDCB, 4'b1111, 4'b0001);
    do_load(70, 16'hF654, 4'b1010, 4'b0010);
    wait_cyc(130);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    phase = 2;
    rst_n = 1'b1;
    do_load(5,  16'h4321, 4'b0001, 4'b0000);
    do_load(40, 16'h9999, 4'b1111, 4'b1111);
    do_load(63, 16'h5A7F, 4'b1111, 4'b1000);
    do_load(98, 16'h8888, 4'b1111, 4'b1111);
    wait_cyc(100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {an, code, dp_n, frame_done}, {4'hF, 4'hF, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    phase = 3;
    rst_n = 1'b1;
    wait_cyc(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
